// File: rtl/dma_cfg_sequencer.sv
// AXI-lite master that programs the S2MM/MM2S channels of an AXI DMA engine,
// then polls both status registers until every enabled channel reports idle.
module dma_cfg_sequencer #(
  parameter int unsigned POLL_GAP = 8,
  parameter int unsigned TIMEOUT  = 65535
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        start,
  input  logic        dma_rst_done,
  input  logic        en_mm2s,
  input  logic        en_s2mm,
  input  logic [31:0] source_addr,
  input  logic [31:0] dest_addr,
  input  logic [31:0] byte_length,
  output logic        busy,
  output logic        done,
  output logic        error,
  output logic [31:0] last_status,
  output logic [9:0]  awaddr,
  output logic        awvalid,
  input  logic        awready,
  output logic [31:0] wdata,
  output logic        wvalid,
  input  logic        wready,
  input  logic [1:0]  bresp,
  input  logic        bvalid,
  output logic        bready,
  output logic [9:0]  araddr,
  output logic        arvalid,
  input  logic        arready,
  input  logic [31:0] rdata,
  input  logic [1:0]  rresp,
  input  logic        rvalid,
  output logic        rready
);

  localparam logic [9:0] S2MM_DMASR = 10'h034;
  localparam logic [9:0] MM2S_DMASR = 10'h004;
  localparam int GAP_W = (POLL_GAP > 1) ? $clog2(POLL_GAP) : 1;

  typedef enum logic [2:0] {
    S_IDLE, S_WRITE, S_WRESP, S_POLL_WAIT, S_RADDR, S_RDATA, S_FINISH
  } state_t;

  state_t            state;
  logic              en_mm2s_q, en_s2mm_q;
  logic [31:0]       src_q, dst_q;
  logic [25:0]       len_q;
  logic [2:0]        wr_idx;
  logic [GAP_W-1:0]  gap_cnt;
  logic [31:0]       tmo_cnt;
  logic              s2mm_idle, mm2s_idle, rd_mm2s;

  logic              accept, wr_last, s2mm_now, mm2s_now, all_idle, tmo_hit;
  logic [2:0]        wr_next, wr_first;

  // Entries 0..2 program S2MM, 3..5 program MM2S; disabled channels are skipped.
  function automatic logic [9:0] entry_addr(input logic [2:0] idx);
    case (idx)
      3'd0:    return 10'h030;
      3'd1:    return 10'h048;
      3'd2:    return 10'h058;
      3'd3:    return 10'h000;
      3'd4:    return 10'h018;
      default: return 10'h028;
    endcase
  endfunction

  function automatic logic [31:0] entry_data(input logic [2:0] idx, input logic [31:0] src,
                                             input logic [31:0] dst, input logic [25:0] len);
    case (idx)
      3'd0, 3'd3: return 32'd1;
      3'd1:       return dst;
      3'd4:       return src;
      default:    return {6'b0, len};
    endcase
  endfunction

  // NOTE: every signal written here gets a value on every path, so no latch is inferred.
  always_comb begin
    accept   = start & dma_rst_done & (en_mm2s | en_s2mm);
    wr_first = en_s2mm ? 3'd0 : 3'd3;
    wr_last  = (wr_idx == 3'd5) || ((wr_idx == 3'd2) && !en_mm2s_q);
    wr_next  = (wr_idx == 3'd2) ? 3'd3 : wr_idx + 3'd1;
    s2mm_now = s2mm_idle | (~rd_mm2s & rdata[1]);
    mm2s_now = mm2s_idle | (rd_mm2s & rdata[1]);
    all_idle = (~en_s2mm_q | s2mm_now) & (~en_mm2s_q | mm2s_now);
    tmo_hit  = (tmo_cnt >= TIMEOUT);
  end

  // NOTE: state uses non-blocking assignments so every register sees pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= S_IDLE;
      busy        <= 1'b0;
      done        <= 1'b0;
      error       <= 1'b0;
      last_status <= '0;
      awaddr      <= '0;
      awvalid     <= 1'b0;
      wdata       <= '0;
      wvalid      <= 1'b0;
      bready      <= 1'b0;
      araddr      <= '0;
      arvalid     <= 1'b0;
      rready      <= 1'b0;
      en_mm2s_q   <= 1'b0;
      en_s2mm_q   <= 1'b0;
      src_q       <= '0;
      dst_q       <= '0;
      len_q       <= '0;
      wr_idx      <= '0;
      gap_cnt     <= '0;
      tmo_cnt     <= '0;
      s2mm_idle   <= 1'b0;
      mm2s_idle   <= 1'b0;
      rd_mm2s     <= 1'b0;
    end else begin
      if ((state == S_POLL_WAIT || state == S_RADDR || state == S_RDATA) && tmo_cnt != '1)
        tmo_cnt <= tmo_cnt + 32'd1;

      case (state)
        S_IDLE: begin
          if (accept) begin
            busy      <= 1'b1;
            en_mm2s_q <= en_mm2s;
            en_s2mm_q <= en_s2mm;
            src_q     <= source_addr;
            dst_q     <= dest_addr;
            len_q     <= byte_length[25:0];
            s2mm_idle <= 1'b0;
            mm2s_idle <= 1'b0;
            if (byte_length[25:0] == '0) begin
              error <= 1'b1;
              state <= S_FINISH;
            end else begin
              wr_idx  <= wr_first;
              awaddr  <= entry_addr(wr_first);
              wdata   <= entry_data(wr_first, source_addr, dest_addr, byte_length[25:0]);
              awvalid <= 1'b1;
              wvalid  <= 1'b1;
              state   <= S_WRITE;
            end
          end
        end

        // A low valid means that channel's handshake already completed.
        S_WRITE: begin
          if (awready) awvalid <= 1'b0;
          if (wready)  wvalid  <= 1'b0;
          if ((!awvalid || awready) && (!wvalid || wready)) begin
            bready <= 1'b1;
            state  <= S_WRESP;
          end
        end

        S_WRESP: begin
          if (bvalid) begin
            bready <= 1'b0;
            if (bresp != 2'b00) begin
              error <= 1'b1;
              state <= S_FINISH;
            end else if (wr_last) begin
              gap_cnt <= '0;
              tmo_cnt <= '0;
              state   <= S_POLL_WAIT;
            end else begin
              wr_idx  <= wr_next;
              awaddr  <= entry_addr(wr_next);
              wdata   <= entry_data(wr_next, src_q, dst_q, len_q);
              awvalid <= 1'b1;
              wvalid  <= 1'b1;
              state   <= S_WRITE;
            end
          end
        end

        S_POLL_WAIT: begin
          if (tmo_hit) begin
            error <= 1'b1;
            state <= S_FINISH;
          end else if (gap_cnt == GAP_W'(POLL_GAP - 1)) begin
            rd_mm2s <= !(en_s2mm_q && !s2mm_idle);
            araddr  <= (en_s2mm_q && !s2mm_idle) ? S2MM_DMASR : MM2S_DMASR;
            arvalid <= 1'b1;
            state   <= S_RADDR;
          end else begin
            gap_cnt <= gap_cnt + 1'b1;
          end
        end

        S_RADDR: begin
          if (arready) begin
            arvalid <= 1'b0;
            rready  <= 1'b1;
            state   <= S_RDATA;
          end
        end

        S_RDATA: begin
          if (rvalid) begin
            rready      <= 1'b0;
            last_status <= rdata;
            s2mm_idle   <= s2mm_now;
            mm2s_idle   <= mm2s_now;
            if (rresp != 2'b00 || rdata[6:4] != 3'b000) begin
              error <= 1'b1;
              state <= S_FINISH;
            end else if (!rd_mm2s && en_mm2s_q && !mm2s_idle) begin
              rd_mm2s <= 1'b1;
              araddr  <= MM2S_DMASR;
              arvalid <= 1'b1;
              state   <= S_RADDR;
            end else if (all_idle) begin
              done  <= 1'b1;
              state <= S_FINISH;
            end else if (tmo_hit) begin
              error <= 1'b1;
              state <= S_FINISH;
            end else begin
              gap_cnt <= '0;
              state   <= S_POLL_WAIT;
            end
          end
        end

        S_FINISH: begin
          done  <= 1'b0;
          error <= 1'b0;
          busy  <= 1'b0;
          state <= S_IDLE;
        end

        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_dma_cfg_sequencer.sv
// Directed and randomized checks of dma_cfg_sequencer against an AXI-lite slave
// model and a transaction-level reference of the expected register writes and polls.
module tb_dma_cfg_sequencer;

  localparam int PG  = 4;
  localparam int TMO = 50;

  logic        clk = 1'b0, rst_n = 1'b0, start = 1'b0, dma_rst_done = 1'b0;
  logic        en_mm2s = 1'b0, en_s2mm = 1'b0;
  logic [31:0] source_addr = '0, dest_addr = '0, byte_length = '0;
  logic        busy, done, error;
  logic [31:0] last_status;
  logic [9:0]  awaddr, araddr;
  logic [31:0] wdata;
  logic        awvalid, wvalid, bready, arvalid, rready;
  logic        awready = 1'b0, wready = 1'b0, bvalid = 1'b0, arready = 1'b0, rvalid = 1'b0;
  logic [1:0]  bresp = 2'b00, rresp = 2'b00;
  logic [31:0] rdata = '0;

  int n_checks = 0;
  int n_fail   = 0;

  // Slave configuration and observed traffic
  int          aw_delay = 0, w_delay = 0;
  logic [31:0] rsp_q[$];
  logic [1:0]  bresp_q[$];
  logic [9:0]  aw_log[$], ar_log[$];
  logic [31:0] w_log[$];
  int          gap_log[$];
  int          split_cycles = 0, viol = 0;

  // Reference expectations
  logic [9:0]  exp_aw[$], exp_ar[$];
  logic [31:0] exp_w[$];
  logic [31:0] exp_last;

  // Slave process state
  logic aw_hs, w_hs, b_hs, ar_hs, r_hs;
  logic aw_got = 1'b0, w_got = 1'b0, gap_on = 1'b0;
  logic p_aw = 1'b0, p_w = 1'b0, p_ar = 1'b0, p_aw_hs = 1'b0, p_w_hs = 1'b0, p_ar_hs = 1'b0, p_rst = 1'b0;
  int   aw_cnt = 0, w_cnt = 0, gap_n = 0;

  dma_cfg_sequencer #(.POLL_GAP(PG), .TIMEOUT(TMO)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .dma_rst_done(dma_rst_done),
    .en_mm2s(en_mm2s), .en_s2mm(en_s2mm), .source_addr(source_addr),
    .dest_addr(dest_addr), .byte_length(byte_length), .busy(busy), .done(done),
    .error(error), .last_status(last_status), .awaddr(awaddr), .awvalid(awvalid),
    .awready(awready), .wdata(wdata), .wvalid(wvalid), .wready(wready),
    .bresp(bresp), .bvalid(bvalid), .bready(bready), .araddr(araddr),
    .arvalid(arvalid), .arready(arready), .rdata(rdata), .rresp(rresp),
    .rvalid(rvalid), .rready(rready)
  );

  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // AXI-lite slave: handshakes are observed mid-cycle and retired at the next edge.
  initial begin
    forever begin
      @(negedge clk);
      aw_hs = awvalid & awready;
      w_hs  = wvalid & wready;
      b_hs  = bvalid & bready;
      ar_hs = arvalid & arready;
      r_hs  = rvalid & rready;
      if (aw_hs) aw_log.push_back(awaddr);
      if (w_hs)  w_log.push_back(wdata);
      if (ar_hs) ar_log.push_back(araddr);
      if (awvalid && !wvalid) split_cycles++;
      if (rst_n && p_rst) begin
        if (p_aw && !p_aw_hs && !awvalid) viol++;
        if (p_w  && !p_w_hs  && !wvalid)  viol++;
        if (p_ar && !p_ar_hs && !arvalid) viol++;
      end
      p_aw = awvalid; p_w = wvalid; p_ar = arvalid;
      p_aw_hs = aw_hs; p_w_hs = w_hs; p_ar_hs = ar_hs; p_rst = rst_n;
      if (gap_on && arvalid) begin
        gap_log.push_back(gap_n);
        gap_on = 1'b0;
      end else if (gap_on && !rready) begin
        gap_n++;
      end
      if (r_hs) begin
        gap_on = 1'b1;
        gap_n  = 0;
      end

      @(posedge clk);
      #1;
      if (!rst_n) begin
        awready = 1'b0; wready = 1'b0; bvalid = 1'b0; arready = 1'b0; rvalid = 1'b0;
        aw_got = 1'b0; w_got = 1'b0; aw_cnt = 0; w_cnt = 0;
      end else begin
        if (b_hs) bvalid = 1'b0;
        if (r_hs) rvalid = 1'b0;
        if (aw_hs) aw_got = 1'b1;
        if (w_hs)  w_got  = 1'b1;
        if (aw_got && w_got && !bvalid) begin
          bvalid = 1'b1;
          bresp  = (bresp_q.size() > 0) ? bresp_q.pop_front() : 2'b00;
          aw_got = 1'b0;
          w_got  = 1'b0;
        end
        if (awvalid) begin awready = (aw_cnt >= aw_delay); aw_cnt++; end
        else begin awready = 1'b0; aw_cnt = 0; end
        if (wvalid) begin wready = (w_cnt >= w_delay); w_cnt++; end
        else begin wready = 1'b0; w_cnt = 0; end
        arready = arvalid;
        if (ar_hs) begin
          rvalid = 1'b1;
          rresp  = 2'b00;
          rdata  = (rsp_q.size() > 0) ? rsp_q.pop_front() : 32'h0000_0002;
        end
      end
    end
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  task automatic expect_writes(input logic es, input logic em, input logic [31:0] src,
                               input logic [31:0] dst, input logic [31:0] len);
    exp_aw.delete();
    exp_w.delete();
    if (es) begin
      exp_aw.push_back(10'h030); exp_w.push_back(32'd1);
      exp_aw.push_back(10'h048); exp_w.push_back(dst);
      exp_aw.push_back(10'h058); exp_w.push_back(len & 32'h03FF_FFFF);
    end
    if (em) begin
      exp_aw.push_back(10'h000); exp_w.push_back(32'd1);
      exp_aw.push_back(10'h018); exp_w.push_back(src);
      exp_aw.push_back(10'h028); exp_w.push_back(len & 32'h03FF_FFFF);
    end
  endtask

  // Poll plan: each enabled channel is read every round until its status shows idle.
  task automatic plan_polls(input logic es, input logic em, input int max_busy);
    logic ps, pm, idle;
    int   ls, lm;
    logic [31:0] v;
    rsp_q.delete();
    exp_ar.delete();
    ps = es; pm = em; ls = max_busy; lm = max_busy;
    while (ps || pm) begin
      if (ps) begin
        idle = (ls == 0) || ($urandom_range(0, 1) == 1);
        if (!idle) ls--;
        v = ($urandom & 32'hFFFF_FF8D) | (idle ? 32'h2 : 32'h0);
        rsp_q.push_back(v);
        exp_ar.push_back(10'h034);
        if (idle) ps = 1'b0;
      end
      if (pm) begin
        idle = (lm == 0) || ($urandom_range(0, 1) == 1);
        if (!idle) lm--;
        v = ($urandom & 32'hFFFF_FF8D) | (idle ? 32'h2 : 32'h0);
        rsp_q.push_back(v);
        exp_ar.push_back(10'h004);
        if (idle) pm = 1'b0;
      end
    end
    exp_last = rsp_q[$];
  endtask

  task automatic check_traffic(input string t);
    check({t, "_n_aw"}, 32'(aw_log.size()), 32'(exp_aw.size()));
    check({t, "_n_w"},  32'(w_log.size()),  32'(exp_w.size()));
    check({t, "_n_ar"}, 32'(ar_log.size()), 32'(exp_ar.size()));
    for (int i = 0; i < exp_aw.size() && i < aw_log.size(); i++)
      check($sformatf("%s_awaddr%0d", t, i), 32'(aw_log[i]), 32'(exp_aw[i]));
    for (int i = 0; i < exp_w.size() && i < w_log.size(); i++)
      check($sformatf("%s_wdata%0d", t, i), w_log[i], exp_w[i]);
    for (int i = 0; i < exp_ar.size() && i < ar_log.size(); i++)
      check($sformatf("%s_araddr%0d", t, i), 32'(ar_log[i]), 32'(exp_ar[i]));
  endtask

  task automatic clear_logs();
    aw_log.delete(); w_log.delete(); ar_log.delete(); gap_log.delete();
    split_cycles = 0;
    gap_on = 1'b0;
  endtask

  // Issues one start and waits (bounded) for the completion pulse; cyc counts the
  // start cycle as 1. Inputs are scrambled afterwards and a stray start is sent.
  task automatic run(input logic es, input logic em, input logic [31:0] src,
                     input logic [31:0] dst, input logic [31:0] len, input int budget,
                     output int cyc, output logic got_done, output logic got_err,
                     output logic busy_at_end);
    clear_logs();
    @(posedge clk);
    #1;
    start = 1'b1; en_s2mm = es; en_mm2s = em;
    source_addr = src; dest_addr = dst; byte_length = len;
    cyc = 0; got_done = 1'b0; got_err = 1'b0; busy_at_end = 1'b0;
    while (cyc < budget && !got_done && !got_err) begin
      @(negedge clk);
      cyc++;
      got_done    = done;
      got_err     = error;
      busy_at_end = busy;
      if (!got_done && !got_err) begin
        @(posedge clk);
        #1;
        start       = (cyc == 3);
        en_s2mm     = 1'b1;
        en_mm2s     = 1'b1;
        source_addr = $urandom;
        dest_addr   = $urandom;
        byte_length = $urandom;
      end
    end
    start = 1'b0;
  endtask

  task automatic check_end(input string t, input logic exp_done);
    @(negedge clk);
    check({t, "_pulse_cleared"}, 32'({done, error}), 32'(2'b00));
    check({t, "_busy_fell"}, 32'(busy), 32'(1'b0));
    check({t, "_no_viol"}, 32'(viol), 32'(0));
    if (exp_done) check({t, "_last_status"}, last_status, exp_last);
  endtask

  int          cyc, n;
  logic        gd, ge, gb, es, em;
  logic [31:0] src, dst, len, tmp;

  initial begin
    repeat (3) @(posedge clk);
    #1;
    rst_n = 1'b1;
    @(negedge clk);
    check("rst_ctl", 32'({busy, done, error, awvalid, wvalid, bready, arvalid, rready}), 32'(8'h00));
    check("rst_awaddr", 32'(awaddr), 32'(0));
    check("rst_araddr", 32'(araddr), 32'(0));
    check("rst_wdata", wdata, 32'(0));
    check("rst_last_status", last_status, 32'(0));

    // Start while the engine is still in reset, then with both enables low.
    @(posedge clk); #1; start = 1'b1; en_mm2s = 1'b1; byte_length = 32'd8;
    @(posedge clk); #1; start = 1'b0;
    @(negedge clk);
    check("ign_no_rst_done", 32'({busy, awvalid}), 32'(2'b00));
    dma_rst_done = 1'b1;
    @(posedge clk); #1; start = 1'b1; en_mm2s = 1'b0; en_s2mm = 1'b0;
    @(posedge clk); #1; start = 1'b0;
    @(negedge clk);
    check("ign_no_enables", 32'({busy, awvalid}), 32'(2'b00));

    // MM2S only, always-ready slave, idle on the first poll: minimum latency.
    rsp_q = '{32'h0000_0002};
    exp_ar = '{10'h004};
    exp_last = 32'h0000_0002;
    expect_writes(1'b0, 1'b1, 32'h1000_0000, 32'h0, 32'd20);
    run(1'b0, 1'b1, 32'h1000_0000, 32'hDEAD_BEEF, 32'd20, 200, cyc, gd, ge, gb);
    check("t1_result", 32'({gd, ge}), 32'(2'b10));
    check("t1_latency", 32'(cyc), 32'(1 + 3 * 2 + PG + 2 + 1));
    check("t1_busy_at_done", 32'(gb), 32'(1'b1));
    check_traffic("t1");
    check_end("t1", 1'b1);

    // Both channels with awready delayed: wvalid drops first, awvalid holds.
    aw_delay = 3; w_delay = 0;
    rsp_q = '{32'h0000_0002, 32'h0000_0002};
    exp_ar = '{10'h034, 10'h004};
    exp_last = 32'h0000_0002;
    expect_writes(1'b1, 1'b1, 32'h2000_0040, 32'h3000_0080, 32'h0000_1000);
    run(1'b1, 1'b1, 32'h2000_0040, 32'h3000_0080, 32'h0000_1000, 400, cyc, gd, ge, gb);
    check("t2_result", 32'({gd, ge}), 32'(2'b10));
    check("t2_wvalid_drops_first", 32'(split_cycles >= 18), 32'(1));
    check_traffic("t2");
    check_end("t2", 1'b1);
    aw_delay = 0;

    // Second write answered with SLVERR.
    bresp_q = '{2'b00, 2'b10};
    rsp_q.delete();
    exp_ar.delete();
    expect_writes(1'b1, 1'b0, 32'h0, 32'h4000_0000, 32'd64);
    void'(exp_aw.pop_back());
    void'(exp_w.pop_back());
    run(1'b1, 1'b0, 32'h0, 32'h4000_0000, 32'd64, 200, cyc, gd, ge, gb);
    check("t3_result", 32'({gd, ge}), 32'(2'b01));
    check_traffic("t3");
    check_end("t3", 1'b0);
    bresp_q.delete();

    // Two non-idle polls before idle: POLL_GAP quiet cycles between reads.
    rsp_q = '{32'h0000_0000, 32'h0000_0000, 32'h0000_0002};
    exp_ar = '{10'h004, 10'h004, 10'h004};
    exp_last = 32'h0000_0002;
    expect_writes(1'b0, 1'b1, 32'h5000_0000, 32'h0, 32'd128);
    run(1'b0, 1'b1, 32'h5000_0000, 32'h0, 32'd128, 200, cyc, gd, ge, gb);
    check("t4_result", 32'({gd, ge}), 32'(2'b10));
    check("t4_n_gaps", 32'(gap_log.size()), 32'(2));
    for (int i = 0; i < gap_log.size(); i++)
      check($sformatf("t4_gap%0d", i), 32'(gap_log[i]), 32'(PG));
    check_traffic("t4");
    check_end("t4", 1'b1);

    // Zero length in the used bits (upper bits set): error next cycle, no traffic.
    rsp_q.delete();
    exp_aw.delete(); exp_w.delete(); exp_ar.delete();
    run(1'b1, 1'b1, 32'h1, 32'h2, 32'h0400_0000, 50, cyc, gd, ge, gb);
    check("t5_result", 32'({gd, ge}), 32'(2'b01));
    check("t5_latency", 32'(cyc), 32'(2));
    check_traffic("t5");
    check_end("t5", 1'b0);

    // DMASR error bit set.
    rsp_q = '{32'h0000_0010};
    exp_ar = '{10'h034};
    expect_writes(1'b1, 1'b0, 32'h0, 32'h6000_0000, 32'd4);
    run(1'b1, 1'b0, 32'h0, 32'h6000_0000, 32'd4, 200, cyc, gd, ge, gb);
    check("t6_result", 32'({gd, ge}), 32'(2'b01));
    check("t6_last_status", last_status, 32'h0000_0010);
    check_end("t6", 1'b0);

    // DMASR stuck busy: the poll phase times out.
    rsp_q.delete();
    for (int i = 0; i < 20; i++) rsp_q.push_back(32'h0);
    run(1'b0, 1'b1, 32'h7000_0000, 32'h0, 32'd16, 400, cyc, gd, ge, gb);
    check("t7_result", 32'({gd, ge}), 32'(2'b01));
    check("t7_reads_bounded", 32'(ar_log.size() >= 7 && ar_log.size() <= 9), 32'(1));
    check_end("t7", 1'b0);
    rsp_q.delete();

    // Randomized transfers against the reference plan.
    for (int it = 0; it < 5; it++) begin
      n  = $urandom_range(1, 3);
      es = n[0];
      em = n[1];
      src = $urandom;
      dst = $urandom;
      tmp = $urandom;
      len = (tmp & 32'hFC00_0000) | $urandom_range(1, 32'h03FF_FFFF);
      aw_delay = $urandom_range(0, 2);
      w_delay  = $urandom_range(0, 2);
      expect_writes(es, em, src, dst, len);
      plan_polls(es, em, 2);
      run(es, em, src, dst, len, 400, cyc, gd, ge, gb);
      check($sformatf("rnd%0d_result", it), 32'({gd, ge}), 32'(2'b10));
      check_traffic($sformatf("rnd%0d", it));
      check_end($sformatf("rnd%0d", it), 1'b1);
    end
    aw_delay = 0; w_delay = 0;

    // Reset asserted while waiting for a write response.
    clear_logs();
    @(posedge clk); #1;
    start = 1'b1; en_s2mm = 1'b1; en_mm2s = 1'b1; byte_length = 32'd32;
    @(posedge clk); #1; start = 1'b0;
    n = 0;
    while (n < 40 && !bready) begin
      @(negedge clk);
      n++;
    end
    check("rst_reached_wresp", 32'(bready), 32'(1'b1));
    rst_n = 1'b0;
    #1;
    check("midrst_ctl", 32'({busy, done, error, awvalid, wvalid, bready, arvalid, rready}), 32'(8'h00));
    check("midrst_addr", 32'({awaddr, araddr}), 32'(0));
    check("midrst_wdata", wdata, 32'(0));
    check("midrst_last_status", last_status, 32'(0));
    repeat (2) @(negedge clk);
    check("midrst_no_pulse", 32'({done, error}), 32'(2'b00));
    rst_n = 1'b1;

    rsp_q = '{32'h0000_0002, 32'h0000_0002};
    exp_ar = '{10'h034, 10'h004};
    exp_last = 32'h0000_0002;
    expect_writes(1'b1, 1'b1, 32'h8000_0000, 32'h9000_0000, 32'd256);
    run(1'b1, 1'b1, 32'h8000_0000, 32'h9000_0000, 32'd256, 200, cyc, gd, ge, gb);
    check("t8_result", 32'({gd, ge}), 32'(2'b10));
    check("t8_latency", 32'(cyc), 32'(1 + 6 * 2 + PG + 4 + 1));
    check_traffic("t8");
    check_end("t8", 1'b1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
